load_align_unit: RTL

- Parametrised, handshaked load path between the MEM stage and a variable-latency data memory.
- Accepts one load request (address and load type) at a time, issues a lane-aligned word read, waits for the memory acknowledge, then returns the selected byte, halfword or word, sign- or zero-extended.
- Detects misaligned addresses and flags them as an address-error exception without touching memory.
- Supports a pipeline flush that discards in-flight work.

---
 rtl/load_pkg.sv | 35 +++
 rtl/load_align_unit_if.sv | 36 +++
 rtl/lane_extract.sv | 30 +++
 rtl/load_align_unit.sv | 99 +++++++++
 4 files changed

// File: rtl/load_pkg.sv
// Shared definitions for the load alignment path:
// load-type codes, FSM states and the per-type alignment mask.
package load_pkg;

  localparam logic [5:0] T_LW  = 6'b000110;
  localparam logic [5:0] T_LH  = 6'b010001;
  localparam logic [5:0] T_LB  = 6'b010010;
  localparam logic [5:0] T_LHU = 6'b010011;
  localparam logic [5:0] T_LBU = 6'b010100;
  localparam logic [5:0] T_LD  = 6'b000111;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    DRAIN
  } state_t;

  // Address bits that must be zero; LD only counts on a 64-bit bus.
  function automatic logic [2:0] align_mask(
    input logic [5:0] t,
    input logic       wide
  );
    logic [2:0] m;
    m = 3'b000;
    case (t)
      T_LW:        m = 3'b011;
      T_LH, T_LHU: m = 3'b001;
      T_LD:        m = wide ? 3'b111 : 3'b000;
      default:     m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_align_unit_if.sv
// Request, memory and response signals of the load path.
// slave is the load unit side, master the MEM-stage/memory side.
interface load_align_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TYPE_W = 6
);

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [TYPE_W-1:0] in_type;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_exc;

  modport slave (
    input  in_valid, in_addr, in_type,
    input  mem_ack, mem_rdata, out_ready,
    output in_ready, mem_req, mem_addr,
    output out_valid, out_data, out_exc
  );

  modport master (
    output in_valid, in_addr, in_type,
    output mem_ack, mem_rdata, out_ready,
    input  in_ready, mem_req, mem_addr,
    input  out_valid, out_data, out_exc
  );

endinterface

// File: rtl/lane_extract.sv
// Selects the addressed byte/halfword/word lane of a memory word
// and sign- or zero-extends it to the full bus width.
module lane_extract
  import load_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OW     = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [OW-1:0]     offset,
  input  logic [5:0]        typ,
  output logic [DATA_W-1:0] res
);

  logic [DATA_W-1:0] sh;

  always_comb begin
    sh  = rdata >> {offset, 3'b000};
    res = rdata;
    unique case (1'b1)
      typ == T_LB:  res = DATA_W'($signed(sh[7:0]));
      typ == T_LBU: res = DATA_W'(sh[7:0]);
      typ == T_LH:  res = DATA_W'($signed(sh[15:0]));
      typ == T_LHU: res = DATA_W'(sh[15:0]);
      typ == T_LW:  res = DATA_W'($signed(sh[31:0]));
      default:      res = rdata;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// Handshaked load path: align check, word read from a variable
// latency memory, lane extraction and flush handling.
module load_align_unit
  import load_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TYPE_W = 6
) (
  input logic clk,
  input logic reset,
  input logic flush,
  load_align_unit_if.slave bus
);

  localparam int OW = $clog2(DATA_W / 8);

  state_t            state;
  logic [OW-1:0]     off_q;
  logic [5:0]        type_q;
  logic [DATA_W-1:0] lane;
  logic              mis;

  assign bus.in_ready = (state == IDLE) && !flush;

  assign mis = |(bus.in_addr[2:0] &
                 align_mask(6'(bus.in_type), DATA_W == 64));

  lane_extract #(
    .DATA_W (DATA_W)
  ) u_lane (
    .rdata  (bus.mem_rdata),
    .offset (off_q),
    .typ    (type_q),
    .res    (lane)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      off_q         <= '0;
      type_q        <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_addr  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_exc   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            off_q  <= bus.in_addr[OW-1:0];
            type_q <= 6'(bus.in_type);
            if (mis) begin
              state         <= RESP;
              bus.out_valid <= 1'b1;
              bus.out_exc   <= 1'b1;
              bus.out_data  <= '0;
            end else begin
              state        <= WAIT;
              bus.mem_req  <= 1'b1;
              bus.mem_addr <= {bus.in_addr[ADDR_W-1:OW],
                               {OW{1'b0}}};
            end
          end
        end
        WAIT: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            if (flush) begin
              state <= IDLE;
            end else begin
              state         <= RESP;
              bus.out_valid <= 1'b1;
              bus.out_data  <= lane;
              bus.out_exc   <= 1'b0;
            end
          end else if (flush) begin
            // read already issued: must still absorb its ack
            state <= DRAIN;
          end
        end
        RESP: begin
          if (flush || bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (bus.mem_ack) begin
            state       <= IDLE;
            bus.mem_req <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
